// File: rtl/mio_arbiter.sv
// rtl/mio_arbiter.sv - two-master arbiter and access sequencer for the memory/IO decoder port
// M0 has fixed priority; a burst counter forces M1 in after MAX_BURST contended M0 grants.
module mio_arbiter #(
  parameter int RD_WAIT   = 1,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_a,
  output logic [31:0] d_t_mem,
  output logic        wmem,
  output logic        rmem,
  input  logic [31:0] d_f_mem,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUS, ACK} state_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);
  localparam logic [2:0] WAIT_INIT = 3'(RD_WAIT);

  state_t      state, state_nx;
  logic        owner;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  burst_cnt;
  logic [2:0]  wait_cnt;
  logic        win;

  // Winner when arbitrating in IDLE: 1 selects M1.
  assign win = m1_req && (!m0_req || (burst_cnt == BURST_MAX));

  always_comb begin
    state_nx = state;
    mem_a    = 32'h0;
    d_t_mem  = 32'h0;
    wmem     = 1'b0;
    rmem     = 1'b0;
    m0_gnt   = 1'b0;
    m1_gnt   = 1'b0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) state_nx = BUS;
      end
      BUS: begin
        mem_a  = lat_addr;
        m0_gnt = !owner;
        m1_gnt = owner;
        if (lat_we) begin
          d_t_mem  = lat_wdata;
          wmem     = 1'b1;
          state_nx = ACK;
        end else begin
          rmem = 1'b1;
          if (wait_cnt == 3'd0) state_nx = ACK;
        end
      end
      ACK: begin
        mem_a    = lat_addr;
        m0_gnt   = !owner;
        m1_gnt   = owner;
        m0_ack   = !owner;
        m1_ack   = owner;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      burst_cnt <= 4'd0;
      wait_cnt  <= 3'd0;
      m0_rdata  <= 32'h0;
      m1_rdata  <= 32'h0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            owner     <= win;
            lat_we    <= win ? m1_we    : m0_we;
            lat_addr  <= win ? m1_addr  : m0_addr;
            lat_wdata <= win ? m1_wdata : m0_wdata;
            wait_cnt  <= WAIT_INIT;
            if (!win && m1_req) begin
              if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 4'd1;
            end else begin
              burst_cnt <= 4'd0;
            end
          end
        end
        BUS: begin
          if (!lat_we) begin
            if (wait_cnt == 3'd0) begin
              if (owner) m1_rdata <= d_f_mem;
              else       m0_rdata <= d_f_mem;
            end else begin
              wait_cnt <= wait_cnt - 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_arbiter.sv
// tb/tb_mio_arbiter.sv - self-checking bench for mio_arbiter
// Directed vector table, corner sequences, and random traffic against a transaction-offset model.
module tb_mio_arbiter;

  localparam int RD_WAIT   = 1;
  localparam int MAX_BURST = 4;
  localparam bit O = 1'b0;
  localparam bit I = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = 32'h0, m0_wdata = 32'h0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = 32'h0, m1_wdata = 32'h0;
  logic [31:0] d_f_mem = 32'h0;
  logic        m0_gnt, m0_ack, m1_gnt, m1_ack, wmem, rmem, busy;
  logic [31:0] m0_rdata, m1_rdata, mem_a, d_t_mem;

  int vectors = 0;
  int miscompares = 0;

  mio_arbiter #(.RD_WAIT(RD_WAIT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_a(mem_a), .d_t_mem(d_t_mem), .wmem(wmem), .rmem(rmem),
    .d_f_mem(d_f_mem), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: a granted transfer is a fixed timeline of offsets 1..len after the grant edge.
  bit          m_act = 0;
  int          m_t = 0;
  bit          m_own = 0;
  bit          m_we = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  int          m_burst = 0;
  logic [31:0] m_rd [2] = '{32'h0, 32'h0};

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clock();
    int  len;
    bit  pick_m1;
    if (rst) begin
      m_act = 0; m_t = 0; m_burst = 0; m_own = 0;
      m_rd[0] = 0; m_rd[1] = 0;
    end else if (!m_act) begin
      if (m0_req || m1_req) begin
        pick_m1 = !m0_req || (m1_req && m_burst == MAX_BURST);
        if (!pick_m1 && m1_req) m_burst = (m_burst + 1 > MAX_BURST) ? MAX_BURST : m_burst + 1;
        else m_burst = 0;
        m_own   = pick_m1;
        m_we    = pick_m1 ? m1_we    : m0_we;
        m_addr  = pick_m1 ? m1_addr  : m0_addr;
        m_wdata = pick_m1 ? m1_wdata : m0_wdata;
        m_act   = 1; m_t = 1;
      end
    end else begin
      len = m_we ? 2 : 2 + RD_WAIT;
      if (!m_we && m_t == 1 + RD_WAIT) m_rd[m_own] = d_f_mem;
      if (m_t == len) begin m_act = 0; m_t = 0; end
      else m_t++;
    end
  endtask

  task automatic check_model();
    int          len;
    logic        ew, er, eg0, eg1, ek0, ek1;
    logic [31:0] ea, ed;
    len = m_we ? 2 : 2 + RD_WAIT;
    ew = 0; er = 0; eg0 = 0; eg1 = 0; ek0 = 0; ek1 = 0; ea = 0; ed = 0;
    if (m_act) begin
      ea  = m_addr;
      eg0 = !m_own;
      eg1 = m_own;
      if (m_t == len) begin
        ek0 = !m_own;
        ek1 = m_own;
      end else if (m_we) begin
        ew = 1; ed = m_wdata;
      end else begin
        er = 1;
      end
    end
    chk("model", {25'h0, busy, m0_gnt, m1_gnt, m0_ack, m1_ack, wmem, rmem, mem_a, d_t_mem, m0_rdata, m1_rdata},
                 {25'h0, m_act ? 1'b1 : 1'b0, eg0, eg1, ek0, ek1, ew, er, ea, ed, m_rd[0], m_rd[1]});
  endtask

  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1; m0_req = 0; m1_req = 0;
    step();
    rst = 0;
  endtask

  task automatic run_until_ack(input bit which, input string name);
    for (int c = 0; c < 20; c++) begin
      step();
      if (which ? m1_ack : m0_ack) return;
    end
    miscompares++;
    $display("FAIL %s: no ack within 20 cycles", name);
  endtask

  typedef struct {
    logic        rst;
    logic        m0_req, m0_we;
    logic [31:0] m0_addr, m0_wdata;
    logic        m1_req, m1_we;
    logic [31:0] m1_addr, d_f_mem;
    logic        e_wmem, e_rmem, e_gnt0, e_gnt1, e_ack0, e_ack1, e_busy;
    logic [31:0] e_mem_a, e_dtm, e_rd0, e_rd1;
  } vec_t;

  vec_t vecs [8];
  int   exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int   order [$];

  initial begin
    vecs[0] = '{I, O,O,0,0,            O,O,0,0,            O,O,O,O,O,O,O, 0,0,0,0};
    vecs[1] = '{O, I,I,32'h10,32'hDEADBEEF, O,O,0,0,       I,O,I,O,O,O,I, 32'h10,32'hDEADBEEF,0,0};
    vecs[2] = '{O, I,I,32'h10,32'hDEADBEEF, O,O,0,0,       O,O,I,O,I,O,I, 32'h10,0,0,0};
    vecs[3] = '{O, O,O,0,0,            O,O,0,0,            O,O,O,O,O,O,O, 0,0,0,0};
    vecs[4] = '{O, O,O,0,0,            I,O,32'hC0000004,0, O,I,O,I,O,O,I, 32'hC0000004,0,0,0};
    vecs[5] = '{O, O,O,0,0,            I,O,32'hC0000004,0, O,I,O,I,O,O,I, 32'hC0000004,0,0,0};
    vecs[6] = '{O, O,O,0,0,            I,O,32'hC0000004,32'h41, O,O,O,I,O,I,I, 32'hC0000004,0,0,32'h41};
    vecs[7] = '{O, O,O,0,0,            O,O,0,0,            O,O,O,O,O,O,O, 0,0,0,32'h41};

    for (int i = 0; i < 8; i++) begin
      rst = vecs[i].rst;
      m0_req = vecs[i].m0_req; m0_we = vecs[i].m0_we;
      m0_addr = vecs[i].m0_addr; m0_wdata = vecs[i].m0_wdata;
      m1_req = vecs[i].m1_req; m1_we = vecs[i].m1_we;
      m1_addr = vecs[i].m1_addr; m1_wdata = 32'h0;
      d_f_mem = vecs[i].d_f_mem;
      step();
      chk($sformatf("vec%0d", i),
          {25'h0, wmem, rmem, m0_gnt, m1_gnt, m0_ack, m1_ack, busy, mem_a, d_t_mem, m0_rdata, m1_rdata},
          {25'h0, vecs[i].e_wmem, vecs[i].e_rmem, vecs[i].e_gnt0, vecs[i].e_gnt1, vecs[i].e_ack0,
           vecs[i].e_ack1, vecs[i].e_busy, vecs[i].e_mem_a, vecs[i].e_dtm, vecs[i].e_rd0, vecs[i].e_rd1});
    end

    // Starvation guard with both masters requesting continuously.
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'h1111;
    m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'h2222;
    order.delete();
    for (int c = 0; c < 100 && order.size() < 10; c++) begin
      step();
      chk("no_dual_gnt", {159'h0, m0_gnt && m1_gnt}, 160'h0);
      chk("no_dual_ack", {159'h0, m0_ack && m1_ack}, 160'h0);
      if (m0_ack) order.push_back(0);
      if (m1_ack) order.push_back(1);
    end
    if (order.size() != 10) begin
      vectors++; miscompares++;
      $display("FAIL grant_order: only %0d grants seen, required 10", order.size());
    end else begin
      for (int k = 0; k < 10; k++)
        chk($sformatf("grant_order%0d", k), 160'(order[k]), 160'(exp_order[k]));
    end

    // Simultaneous request after reset: M0 first, M1 next once M0 drops.
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 32'h50;
    m1_req = 1; m1_we = 0; m1_addr = 32'h60; d_f_mem = 32'hABCD;
    step();
    chk("sim_first_gnt", {158'h0, m0_gnt, m1_gnt}, {158'h0, 2'b10});
    run_until_ack(0, "sim_m0_ack");
    m0_req = 0;
    run_until_ack(1, "sim_m1_ack");
    chk("sim_rdata", {96'h0, m0_rdata, m1_rdata}, {96'h0, 32'hABCD, 32'hABCD});
    m1_req = 0;
    step();

    // Reset in the middle of a read wait.
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 32'h300; d_f_mem = 32'h5555;
    step();
    chk("rstrd_bus", {126'h0, rmem, busy, mem_a}, {126'h0, 2'b11, 32'h300});
    rst = 1;
    step();
    chk("rstrd_abort", {126'h0, rmem, busy, m0_ack, m0_rdata}, 160'h0);
    rst = 0;
    step();
    chk("rstrd_restart", {126'h0, busy, rmem, mem_a}, {126'h0, 2'b11, 32'h300});
    run_until_ack(0, "rstrd_ack");
    chk("rstrd_rdata", {128'h0, m0_rdata}, {128'h0, 32'h5555});
    m0_req = 0;
    step();

    // Address change during a read must not disturb the latched address.
    m0_req = 1; m0_we = 0; m0_addr = 32'h100; d_f_mem = 32'h77;
    step();
    m0_addr = 32'h200;
    step();
    chk("addr_hold_bus", {127'h0, rmem, mem_a}, {127'h0, 1'b1, 32'h100});
    step();
    chk("addr_hold_ack", {127'h0, m0_ack, mem_a}, {127'h0, 1'b1, 32'h100});
    m0_req = 0;
    step();

    // Random traffic, occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 199) == 0);
      m0_req   = ($urandom_range(0, 3) != 0);
      m0_we    = $urandom_range(0, 1);
      m0_addr  = $urandom;
      m0_wdata = $urandom;
      m1_req   = ($urandom_range(0, 2) != 0);
      m1_we    = $urandom_range(0, 1);
      m1_addr  = $urandom;
      m1_wdata = $urandom;
      d_f_mem  = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mio_arbiter.md
Name: mio_arbiter

Overview:
Two-master arbiter and access sequencer in front of the memory/IO bus decoder. It shares that decoder's single master port between the CPU data port (M0) and a DMA/blit engine (M1). It latches each request, drives mem_a/d_t_mem/wmem/rmem with correct timing, inserts read wait states for synchronous RAM/VRAM/IO, and returns a one-cycle ack with captured read data. M0 has fixed priority, with a starvation guard for M1.

Parameters:
RD_WAIT, 1, extra cycles rmem is held before d_f_mem is sampled (0..7)
MAX_BURST, 4, consecutive M0 grants allowed while M1 is waiting before M1 is forced in (1..15)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
m0_req  input  1  M0 access request; held until m0_ack
m0_we  input  1  M0 1=write, 0=read
m0_addr  input  32  M0 byte address
m0_wdata  input  32  M0 write data
m0_gnt  output  1  M0 owns bus (BUS and ACK states)
m0_ack  output  1  one-cycle completion pulse to M0
m0_rdata  output  32  M0 read data, valid with m0_ack, held until next M0 read completes
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_ack, m1_rdata  same as M0, for M1
mem_a  output  32  address to bus decoder
d_t_mem  output  32  write data to bus decoder
wmem  output  1  write strobe to bus decoder
rmem  output  1  read strobe to bus decoder
d_f_mem  input  32  read data from bus decoder
busy  output  1  1 in any state other than IDLE

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high.
- Reset values: state=IDLE; mem_a, d_t_mem, m0_rdata, m1_rdata = 0; wmem, rmem, gnt, ack, busy = 0; owner=M0; burst_cnt=0; wait_cnt=0.
- States:
  - IDLE: no strobes; mem_a and d_t_mem driven 0. If any req is high, select a winner, latch its we/addr/wdata into internal registers, set owner, and go to BUS next cycle.
  - BUS: mem_a = latched addr; gnt(owner)=1.
    - Write: d_t_mem = latched wdata; wmem=1 for exactly 1 cycle, then go to ACK.
    - Read: rmem=1 for RD_WAIT+1 cycles with mem_a stable. On the last cycle, capture d_f_mem into rdata(owner), then go to ACK.
    - wmem and rmem are never both 1.
  - ACK: ack(owner)=1 and gnt(owner)=1 for 1 cycle; no strobes; mem_a still latched addr. Always return to IDLE.
- Latency from req sampled high in IDLE (cycle 0):
  - write: wmem in cycle 1, ack in cycle 2
  - read: rmem in cycles 1..1+RD_WAIT, ack in cycle 2+RD_WAIT
  - Minimum request-to-request spacing is 3 cycles for writes. Back-to-back requests are allowed: a master holding req through its ack cycle is re-arbitrated in the following IDLE.
- Arbitration (evaluated in IDLE only):
  - Only one req high: that master wins.
  - Both high: M0 wins unless burst_cnt == MAX_BURST, in which case M1 wins.
- burst_cnt:
  - Increments, saturating at MAX_BURST, on each M0 grant made while m1_req=1.
  - Clears to 0 on any M1 grant, or on an M0 grant made with m1_req=0.
- Requests arriving or changing while not in IDLE are ignored until the next IDLE. Master inputs are sampled only in IDLE; later changes do not affect the transfer in flight.
- Read data: rdata of the non-owner never changes. Writes never modify either rdata register.
- Addresses are passed through unmodified; no alignment or range checking. Unmapped addresses complete normally, with read data as returned by the decoder (0).
- Reset mid-transaction: next cycle is IDLE with all strobes and acks 0. The in-flight access is abandoned with no ack. A partial read leaves rdata unchanged.
- wait_cnt: 3-bit, loaded with RD_WAIT on entry to BUS for reads, counts down; capture occurs when it reaches 0.

Test Plan:
- Single M0 write: addr=0x0000_0010, wdata=0xDEAD_BEEF -> cycle 1: mem_a=0x10, d_t_mem=0xDEADBEEF, wmem=1; cycle 2: m0_ack=1, m0_gnt=1; cycle 3: busy=0, wmem=0.
- M1 read with RD_WAIT=1: addr=0xC000_0004, d_f_mem=0x41 -> rmem=1 in cycles 1-2, mem_a=0xC0000004; cycle 3: m1_ack=1, m1_rdata=0x0000_0041; m0_rdata still 0.
- Starvation guard (MAX_BURST=4): both reqs held high continuously -> grant order M0,M0,M0,M0,M1,M0,M0,M0,M0,M1. Each ack is a single-cycle pulse to the correct master.
- Simultaneous request after reset: m0_req=m1_req=1 rising in the same cycle -> M0 granted first, M1 second; no cycle with both gnts high.
- Reset during read wait (RD_WAIT=3): assert rst in cycle 2 -> cycle 3: rmem=0, busy=0, no ack, rdata unchanged. With req still high, a new transaction starts with BUS in cycle 4.
- Input change mid-transfer: m0_addr changed from 0x100 to 0x200 during BUS of a read -> mem_a stays 0x100 until ACK completes.
